// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, funct fields,
// datapath select codes, FSM states and small decode helpers.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_SRX = 3'b101;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SW   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SB   = 2'b11;

  localparam logic [2:0] RM_LW  = 3'b000;
  localparam logic [2:0] RM_LHU = 3'b001;
  localparam logic [2:0] RM_LBU = 3'b010;
  localparam logic [2:0] RM_LH  = 3'b011;
  localparam logic [2:0] RM_LB  = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  // Only the fields the controller looks at are kept from the fetched word.
  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } instr_fields_t;

  function automatic logic instr_legal(instr_fields_t f);
    logic ok;
    ok = 1'b0;
    case (f.opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: ok = 1'b1;
      OPC_BRANCH: ok = (f.funct3 != 3'b010) && (f.funct3 != 3'b011);
      OPC_LOAD:   ok = f.funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      OPC_STORE:  ok = f.funct3 inside {F3_SB, F3_SH, F3_SW};
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] load_readmode(logic [2:0] funct3);
    logic [2:0] rm;
    case (funct3)
      F3_LB:   rm = RM_LB;
      F3_LH:   rm = RM_LH;
      F3_LBU:  rm = RM_LBU;
      F3_LHU:  rm = RM_LHU;
      default: rm = RM_LW;
    endcase
    return rm;
  endfunction

  function automatic logic [1:0] store_memwrite(logic [2:0] funct3);
    logic [1:0] mw;
    case (funct3)
      F3_SB:   mw = MW_SB;
      F3_SH:   mw = MW_SH;
      F3_SW:   mw = MW_SW;
      default: mw = MW_NONE;
    endcase
    return mw;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller (master) and the
// datapath plus memory/MMIO side (slave).
interface multicycle_controller_if #(
  parameter int MMIO_CHANNELS = 2
);
  logic [31:0]              Instr;
  logic                     instr_valid;
  logic [31:0]              RF_OUT1;
  logic [31:0]              RF_OUT2;
  logic [31:0]              ALUResult;
  logic                     mem_ready;
  logic                     IRWrite;
  logic                     PCWrite;
  logic                     PCSrc;
  logic                     RegWrite;
  logic                     ResultSrc;
  logic                     RF_WD_SRC;
  logic [1:0]               MemWrite;
  logic [1:0]               ALUSrc;
  logic [2:0]               ImmSrc;
  logic [2:0]               READMODE;
  logic [3:0]               ALUControl;
  logic                     mem_req;
  logic [MMIO_CHANNELS-1:0] mmio_rd_en;
  logic [MMIO_CHANNELS-1:0] mmio_wr_en;
  logic                     illegal_instr;
  logic                     bus_error;
  logic [2:0]               state_o;

  modport master (
    input  Instr, instr_valid, RF_OUT1, RF_OUT2, ALUResult, mem_ready,
    output IRWrite, PCWrite, PCSrc, RegWrite, ResultSrc, RF_WD_SRC,
           MemWrite, ALUSrc, ImmSrc, READMODE, ALUControl, mem_req,
           mmio_rd_en, mmio_wr_en, illegal_instr, bus_error, state_o
  );

  modport slave (
    output Instr, instr_valid, RF_OUT1, RF_OUT2, ALUResult, mem_ready,
    input  IRWrite, PCWrite, PCSrc, RegWrite, ResultSrc, RF_WD_SRC,
           MemWrite, ALUSrc, ImmSrc, READMODE, ALUControl, mem_req,
           mmio_rd_en, mmio_wr_en, illegal_instr, bus_error, state_o
  );
endinterface

// File: rtl/mmio_decoder.sv
// Combinational MMIO window decode: address -> {hit, one-hot channel, offset
// within the channel window}.
module mmio_decoder #(
  parameter logic [31:0] BASE     = 32'h0000_0400,
  parameter int          CHANNELS = 2,
  parameter int          STRIDE   = 8,
  parameter int          OFF_W    = $clog2(STRIDE)
) (
  input  logic [31:0]         i_addr,
  output logic                o_hit,
  output logic [CHANNELS-1:0] o_chan,
  output logic [OFF_W-1:0]    o_offset
);

  localparam logic [31:0] SPAN = 32'(CHANNELS * STRIDE);

  logic [31:0] w_rel;
  logic [31:0] w_idx;

  assign w_rel    = i_addr - BASE;
  assign w_idx    = w_rel >> OFF_W;
  assign o_hit    = (i_addr >= BASE) && (w_rel < SPAN);
  assign o_offset = w_rel[OFF_W-1:0];

  always_comb begin
    o_chan = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      o_chan[k] = o_hit && (w_idx == 32'(k));
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing,
// stall-tolerant memory handshake with timeout, and per-channel MMIO strobes.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE     = 32'h0000_0400,
  parameter int          MMIO_CHANNELS = 2,
  parameter int          MMIO_STRIDE   = 8,
  parameter int          MEM_TIMEOUT   = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  localparam int         OFF_W         = $clog2(MMIO_STRIDE);
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  state_e                   r_state;
  state_e                   w_next;
  instr_fields_t            r_ir;
  logic [7:0]               r_wait_cnt;
  logic                     r_mem_first;
  logic                     r_illegal;
  logic                     r_bus_error;

  logic                     w_fetch_take;
  logic                     w_legal;
  logic                     w_is_load;
  logic                     w_is_store;
  logic                     w_is_jump;
  logic                     w_taken;
  logic                     w_timeout;
  logic [1:0]               w_alu_src;
  logic [3:0]               w_alu_ctrl;
  logic [2:0]               w_imm_src;
  logic                     w_mmio_hit;
  logic [MMIO_CHANNELS-1:0] w_mmio_chan;
  logic [OFF_W-1:0]         w_mmio_off;
  logic                     w_unused_instr;

  mmio_decoder #(
    .BASE     (MMIO_BASE),
    .CHANNELS (MMIO_CHANNELS),
    .STRIDE   (MMIO_STRIDE),
    .OFF_W    (OFF_W)
  ) u_mmio_decoder (
    .i_addr   (bus.ALUResult),
    .o_hit    (w_mmio_hit),
    .o_chan   (w_mmio_chan),
    .o_offset (w_mmio_off)
  );

  // Register/immediate fields are consumed by the datapath, not here.
  assign w_unused_instr = ^{bus.Instr[24:15], bus.Instr[11:7], w_mmio_hit};

  assign w_fetch_take = (r_state == ST_FETCH) && bus.instr_valid;
  assign w_legal      = instr_legal(r_ir);
  assign w_is_load    = (r_ir.opcode == OPC_LOAD);
  assign w_is_store   = (r_ir.opcode == OPC_STORE);
  assign w_is_jump    = (r_ir.opcode == OPC_JAL) || (r_ir.opcode == OPC_JALR);
  assign w_timeout    = (r_state == ST_MEM) && !bus.mem_ready &&
                        (r_wait_cnt == TIMEOUT_LIMIT);

  always_comb begin
    case (r_ir.funct3)
      F3_BEQ:  w_taken = (bus.RF_OUT1 == bus.RF_OUT2);
      F3_BNE:  w_taken = (bus.RF_OUT1 != bus.RF_OUT2);
      F3_BLT:  w_taken = ($signed(bus.RF_OUT1) <  $signed(bus.RF_OUT2));
      F3_BGE:  w_taken = ($signed(bus.RF_OUT1) >= $signed(bus.RF_OUT2));
      F3_BLTU: w_taken = (bus.RF_OUT1 <  bus.RF_OUT2);
      F3_BGEU: w_taken = (bus.RF_OUT1 >= bus.RF_OUT2);
      default: w_taken = 1'b0;
    endcase
  end

  // Operand selects: bit0 of ALUSrc picks PC, bit1 picks the immediate.
  always_comb begin
    w_alu_src  = 2'b00;
    w_alu_ctrl = 4'b0000;
    w_imm_src  = IMM_I;
    case (r_ir.opcode)
      OPC_LUI:    begin w_alu_src = 2'b10; w_alu_ctrl = 4'b1111; w_imm_src = IMM_U; end
      OPC_AUIPC:  begin w_alu_src = 2'b11; w_imm_src = IMM_U; end
      OPC_JAL:    begin w_alu_src = 2'b11; w_imm_src = IMM_J; end
      OPC_JALR:   begin w_alu_src = 2'b10; w_imm_src = IMM_I; end
      OPC_BRANCH: begin w_alu_src = 2'b11; w_imm_src = IMM_B; end
      OPC_LOAD:   begin w_alu_src = 2'b10; w_imm_src = IMM_I; end
      OPC_STORE:  begin w_alu_src = 2'b10; w_imm_src = IMM_S; end
      OPC_OP_IMM: begin
        w_alu_src  = 2'b10;
        w_alu_ctrl = {r_ir.funct3, (r_ir.funct3 == F3_SRX) && (r_ir.funct7 == F7_ALT)};
      end
      OPC_OP:     w_alu_ctrl = {r_ir.funct3, r_ir.funct7 == F7_ALT};
      default:    ;
    endcase
  end

  always_comb begin
    // NOTE: every output and the next state get a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    w_next         = r_state;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.PCSrc      = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 1'b0;
    bus.RF_WD_SRC  = 1'b0;
    bus.MemWrite   = MW_NONE;
    bus.ALUSrc     = 2'b00;
    bus.ImmSrc     = 3'b000;
    bus.READMODE   = 3'b000;
    bus.ALUControl = 4'b0000;
    bus.mem_req    = 1'b0;
    bus.mmio_rd_en = '0;
    bus.mmio_wr_en = '0;

    // ALU controls stay valid while the address/result is still consumed.
    if (r_state inside {ST_EXECUTE, ST_MEM, ST_WRITEBACK}) begin
      bus.ALUSrc     = w_alu_src;
      bus.ALUControl = w_alu_ctrl;
      bus.ImmSrc     = w_imm_src;
    end

    unique case (r_state)
      ST_FETCH: begin
        if (bus.instr_valid) begin
          bus.IRWrite = 1'b1;
          w_next      = ST_DECODE;
        end
      end
      ST_DECODE: w_next = w_legal ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: begin
        if (r_ir.opcode == OPC_BRANCH) begin
          bus.PCWrite = 1'b1;
          bus.PCSrc   = w_taken;
          w_next      = ST_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        if (!w_timeout) begin
          bus.mem_req  = 1'b1;
          bus.MemWrite = w_is_store ? store_memwrite(r_ir.funct3) : MW_NONE;
          bus.READMODE = w_is_load ? load_readmode(r_ir.funct3) : 3'b000;
        end
        if (r_mem_first) begin
          if (w_is_store && (w_mmio_off == OFF_W'(0)))
            bus.mmio_wr_en = w_mmio_chan;
          if (w_is_load && (r_ir.funct3 == F3_LW) && (w_mmio_off == OFF_W'(4)))
            bus.mmio_rd_en = w_mmio_chan;
        end
        if (bus.mem_ready) begin
          if (w_is_store) begin
            bus.PCWrite = 1'b1;
            w_next      = ST_FETCH;
          end else begin
            w_next = ST_WRITEBACK;
          end
        end else if (w_timeout) begin
          w_next = ST_TRAP;
        end
      end
      ST_WRITEBACK: begin
        bus.RegWrite  = 1'b1;
        bus.PCWrite   = 1'b1;
        bus.ResultSrc = w_is_load;
        bus.READMODE  = w_is_load ? load_readmode(r_ir.funct3) : 3'b000;
        bus.RF_WD_SRC = w_is_jump;
        bus.PCSrc     = w_is_jump;
        w_next        = ST_FETCH;
      end
      ST_TRAP: w_next = ST_TRAP;
      default: w_next = ST_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_FETCH;
      r_ir        <= '0;
      r_wait_cnt  <= 8'd0;
      r_mem_first <= 1'b0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_mem_first <= (r_state == ST_EXECUTE) && (w_next == ST_MEM);
      if (w_fetch_take)
        r_ir <= '{funct7: bus.Instr[31:25], funct3: bus.Instr[14:12], opcode: bus.Instr[6:0]};
      if ((r_state == ST_MEM) && !bus.mem_ready && !w_timeout)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      else
        r_wait_cnt <= 8'd0;
      if ((r_state == ST_DECODE) && !w_legal)
        r_illegal <= 1'b1;
      if (w_timeout)
        r_bus_error <= 1'b1;
    end
  end

  assign bus.illegal_instr = r_illegal;
  assign bus.bus_error     = r_bus_error;
  assign bus.state_o       = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: ALU op, branches,
// stalled MMIO store/load, timeout trap, illegal opcodes and mid-access reset.
module tb_multicycle_controller;

  localparam logic [31:0] S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_MEM = 3, S_WB = 4, S_TRAP = 5;

  localparam logic [31:0] I_ADD  = 32'h0020_81B3;
  localparam logic [31:0] I_BLT  = 32'h0020_C463;
  localparam logic [31:0] I_BLTU = 32'h0020_E463;
  localparam logic [31:0] I_SB   = 32'h0020_8023;
  localparam logic [31:0] I_SW   = 32'h0020_A023;
  localparam logic [31:0] I_LW   = 32'h0040_A183;
  localparam logic [31:0] I_LB   = 32'h0000_8183;
  localparam logic [31:0] I_JAL  = 32'h0000_00EF;
  localparam logic [31:0] I_BAD  = 32'h0000_007F;
  localparam logic [31:0] I_LBAD = 32'h0040_B183;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_controller_if #(.MMIO_CHANNELS(2)) bus ();

  multicycle_controller #(
    .MMIO_BASE     (32'h0000_0400),
    .MMIO_CHANNELS (2),
    .MMIO_STRIDE   (8),
    .MEM_TIMEOUT   (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Fetch and decode one instruction; returns just after the DECODE edge.
  task automatic issue(input logic [31:0] instr);
    bus.Instr       = instr;
    bus.instr_valid = 1'b1;
    #1;
    check("fetch_irwrite", 32'(bus.IRWrite), 1);
    step();
    bus.instr_valid = 1'b0;
    #1;
    check("decode_state", 32'(bus.state_o), S_DECODE);
    check("decode_irwrite", 32'(bus.IRWrite), 0);
    step();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("rst_state", 32'(bus.state_o), S_FETCH);
    check("rst_illegal", 32'(bus.illegal_instr), 0);
    check("rst_bus_error", 32'(bus.bus_error), 0);
    #1;
    reset = 1'b0;
    step();
  endtask

  initial begin
    int mw_cycles;
    int req_cycles;

    bus.Instr = '0; bus.instr_valid = 1'b0; bus.RF_OUT1 = '0; bus.RF_OUT2 = '0;
    bus.ALUResult = '0; bus.mem_ready = 1'b0;
    reset = 1'b1;
    #12;
    check("reset_state", 32'(bus.state_o), S_FETCH);
    check("reset_irwrite", 32'(bus.IRWrite), 0);
    check("reset_mem_req", 32'(bus.mem_req), 0);
    check("reset_pcwrite", 32'(bus.PCWrite), 0);
    check("reset_memwrite", 32'(bus.MemWrite), 0);
    reset = 1'b0;
    step();

    check("fetch_idle_irwrite", 32'(bus.IRWrite), 0);
    step();
    check("fetch_idle_state", 32'(bus.state_o), S_FETCH);

    // ADD: 4-cycle ALU instruction
    issue(I_ADD);
    check("add_exec_state", 32'(bus.state_o), S_EXEC);
    check("add_alucontrol", 32'(bus.ALUControl), 4'b0000);
    check("add_alusrc", 32'(bus.ALUSrc), 2'b00);
    check("add_exec_pcwrite", 32'(bus.PCWrite), 0);
    step();
    check("add_wb_state", 32'(bus.state_o), S_WB);
    check("add_wb_regwrite", 32'(bus.RegWrite), 1);
    check("add_wb_pcwrite", 32'(bus.PCWrite), 1);
    check("add_wb_resultsrc", 32'(bus.ResultSrc), 0);
    check("add_wb_pcsrc", 32'(bus.PCSrc), 0);
    step();
    check("add_done_state", 32'(bus.state_o), S_FETCH);

    // BLT / BLTU with -1 vs 1
    bus.RF_OUT1 = 32'hFFFF_FFFF;
    bus.RF_OUT2 = 32'h0000_0001;
    issue(I_BLT);
    check("blt_state", 32'(bus.state_o), S_EXEC);
    check("blt_pcwrite", 32'(bus.PCWrite), 1);
    check("blt_pcsrc", 32'(bus.PCSrc), 1);
    check("blt_alusrc", 32'(bus.ALUSrc), 2'b11);
    check("blt_immsrc", 32'(bus.ImmSrc), 3'b010);
    step();
    check("blt_next", 32'(bus.state_o), S_FETCH);
    issue(I_BLTU);
    check("bltu_pcwrite", 32'(bus.PCWrite), 1);
    check("bltu_pcsrc", 32'(bus.PCSrc), 0);
    step();

    // SB to channel 1 offset 0, three stall cycles
    bus.ALUResult = 32'h0000_0408;
    bus.mem_ready = 1'b0;
    issue(I_SB);
    check("sb_exec_immsrc", 32'(bus.ImmSrc), 3'b001);
    check("sb_exec_mem_req", 32'(bus.mem_req), 0);
    step();
    mw_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus.mem_ready = 1'b1;
        #1;
      end
      check("sb_state", 32'(bus.state_o), S_MEM);
      check("sb_mem_req", 32'(bus.mem_req), 1);
      check("sb_wr_en", 32'(bus.mmio_wr_en), (i == 0) ? 2'b10 : 2'b00);
      check("sb_pcwrite", 32'(bus.PCWrite), (i == 3) ? 1 : 0);
      if (bus.MemWrite == 2'b11) mw_cycles++;
      step();
    end
    bus.mem_ready = 1'b0;
    #1;
    check("sb_memwrite_cycles", 32'(mw_cycles), 4);
    check("sb_done_state", 32'(bus.state_o), S_FETCH);
    check("sb_done_memwrite", 32'(bus.MemWrite), 0);

    // LW from channel 0 offset 4, one stall cycle
    bus.ALUResult = 32'h0000_0404;
    issue(I_LW);
    step();
    check("lw_rd_en", 32'(bus.mmio_rd_en), 2'b01);
    check("lw_wr_en", 32'(bus.mmio_wr_en), 2'b00);
    check("lw_readmode", 32'(bus.READMODE), 3'b000);
    check("lw_memwrite", 32'(bus.MemWrite), 0);
    check("lw_mem_req", 32'(bus.mem_req), 1);
    step();
    bus.mem_ready = 1'b1;
    #1;
    check("lw_rd_en_pulse", 32'(bus.mmio_rd_en), 2'b00);
    check("lw_mem_state", 32'(bus.state_o), S_MEM);
    step();
    bus.mem_ready = 1'b0;
    #1;
    check("lw_wb_state", 32'(bus.state_o), S_WB);
    check("lw_wb_resultsrc", 32'(bus.ResultSrc), 1);
    check("lw_wb_regwrite", 32'(bus.RegWrite), 1);
    check("lw_wb_readmode", 32'(bus.READMODE), 3'b000);
    check("lw_wb_pcwrite", 32'(bus.PCWrite), 1);
    step();
    check("lw_done_state", 32'(bus.state_o), S_FETCH);

    // LB at the same address: no read strobe, byte load mode
    issue(I_LB);
    step();
    bus.mem_ready = 1'b1;
    #1;
    check("lb_rd_en", 32'(bus.mmio_rd_en), 2'b00);
    check("lb_readmode", 32'(bus.READMODE), 3'b110);
    step();
    bus.mem_ready = 1'b0;
    #1;
    check("lb_wb_resultsrc", 32'(bus.ResultSrc), 1);
    check("lb_wb_readmode", 32'(bus.READMODE), 3'b110);
    step();

    // JAL writeback selects
    issue(I_JAL);
    check("jal_alusrc", 32'(bus.ALUSrc), 2'b11);
    check("jal_immsrc", 32'(bus.ImmSrc), 3'b100);
    step();
    check("jal_wb_rfwdsrc", 32'(bus.RF_WD_SRC), 1);
    check("jal_wb_pcsrc", 32'(bus.PCSrc), 1);
    check("jal_wb_regwrite", 32'(bus.RegWrite), 1);
    step();

    // SW just past the last channel window: plain memory access
    bus.ALUResult = 32'h0000_0410;
    issue(I_SW);
    step();
    bus.mem_ready = 1'b1;
    #1;
    check("sw_oow_wr_en", 32'(bus.mmio_wr_en), 2'b00);
    check("sw_oow_memwrite", 32'(bus.MemWrite), 2'b01);
    check("sw_oow_mem_req", 32'(bus.mem_req), 1);
    check("sw_oow_pcwrite", 32'(bus.PCWrite), 1);
    step();
    bus.mem_ready = 1'b0;
    #1;
    check("sw_oow_done", 32'(bus.state_o), S_FETCH);

    // LW that never completes: 15 stall cycles then bus_error
    bus.ALUResult = 32'h0000_0404;
    issue(I_LW);
    step();
    check("to_rd_en", 32'(bus.mmio_rd_en), 2'b01);
    req_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.mem_req) req_cycles++;
      step();
    end
    check("to_req_cycles", 32'(req_cycles), 15);
    check("to_last_mem_req", 32'(bus.mem_req), 0);
    check("to_last_state", 32'(bus.state_o), S_MEM);
    step();
    check("to_trap_state", 32'(bus.state_o), S_TRAP);
    check("to_bus_error", 32'(bus.bus_error), 1);
    check("to_trap_mem_req", 32'(bus.mem_req), 0);
    check("to_trap_rd_en", 32'(bus.mmio_rd_en), 0);
    check("to_trap_wr_en", 32'(bus.mmio_wr_en), 0);
    check("to_trap_pcwrite", 32'(bus.PCWrite), 0);
    bus.instr_valid = 1'b1;
    #1;
    check("trap_irwrite", 32'(bus.IRWrite), 0);
    step();
    check("trap_hold", 32'(bus.state_o), S_TRAP);
    check("trap_bus_error_sticky", 32'(bus.bus_error), 1);
    bus.instr_valid = 1'b0;
    pulse_reset();

    // Illegal opcode and illegal load width
    issue(I_BAD);
    check("bad_state", 32'(bus.state_o), S_TRAP);
    check("bad_illegal", 32'(bus.illegal_instr), 1);
    check("bad_bus_error", 32'(bus.bus_error), 0);
    pulse_reset();
    issue(I_LBAD);
    check("lbad_state", 32'(bus.state_o), S_TRAP);
    check("lbad_illegal", 32'(bus.illegal_instr), 1);
    pulse_reset();

    // Reset asserted in the middle of a stalled store
    bus.ALUResult = 32'h0000_0400;
    bus.mem_ready = 1'b0;
    issue(I_SW);
    step();
    check("mid_wr_en", 32'(bus.mmio_wr_en), 2'b01);
    check("mid_memwrite", 32'(bus.MemWrite), 2'b01);
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(bus.state_o), S_FETCH);
    check("mid_rst_mem_req", 32'(bus.mem_req), 0);
    check("mid_rst_memwrite", 32'(bus.MemWrite), 0);
    check("mid_rst_wr_en", 32'(bus.mmio_wr_en), 0);
    check("mid_rst_pcwrite", 32'(bus.PCWrite), 0);
    #1;
    reset = 1'b0;
    step();
    check("post_rst_state", 32'(bus.state_o), S_FETCH);
    check("post_rst_illegal", 32'(bus.illegal_instr), 0);
    check("post_rst_bus_error", 32'(bus.bus_error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
